lcd_frame_downscaler: RTL and testbench
=======================================

# lcd_frame_downscaler

Nearest-neighbour frame downscaler that sits directly upstream of the SDRAM write-port FIFO controller, in the pixel-clock domain. It consumes a raw video stream (frame-start strobe, data-enable, pixel), decimates it from SRC_W×SRC_H to DST_W×DST_H using Bresenham-style accumulators, and drives the FIFO write request, write data and write-port load (address reset / FIFO clear) pulse. Frame bookkeeping detects short, long and aborted frames so the frame buffer is reloaded cleanly on every frame.

## Interface
Parameters:
- DATA_W, 16, pixel width; equals the write-port FIFO data width
- SRC_W, 800, source active pixels per line
- SRC_H, 480, source active lines per frame
- DST_W, 480, output pixels per line; 1 ≤ DST_W ≤ SRC_W
- DST_H, 272, output lines per frame; 1 ≤ DST_H ≤ SRC_H
- LOAD_CYC, 8, wr_load high time in clk cycles; ≥ 4 so the SDRAM-clock-domain edge detector sees it

Ports:
- clk  in  1  pixel clock; the write-port FIFO write clock
- rst  in  1  asynchronous, active-high reset
- vs_in  in  1  frame-start strobe; the rising edge starts a frame
- de_in  in  1  active-pixel enable
- pix_in  in  DATA_W  pixel data, sampled when de_in=1
- wr_req  out  1  FIFO write request, one cycle per kept pixel
- wr_data  out  DATA_W  pixel written with wr_req
- wr_load  out  1  write-port reload pulse, LOAD_CYC cycles wide
- frame_done  out  1  one-cycle pulse when a complete frame has been emitted
- frame_err  out  1  sticky flag; set on a bad frame, cleared only by rst

## Operation
- Registers vs_in and de_in once for edge detection: vs_rise = vs & ~vs_r; de_fall = de_r & ~de.
- State machine: IDLE → LOAD → ACTIVE → IDLE.
  - IDLE: waits for vs_rise, then enters LOAD.
  - LOAD: wr_load=1 for exactly LOAD_CYC cycles. Pixels are dropped. Accumulators and counters are initialised. After LOAD_CYC cycles, enters ACTIVE.
  - ACTIVE: decimates pixels. After SRC_H de_fall events, pulses frame_done (if the frame was good) and enters IDLE.
  - vs_rise in LOAD or ACTIVE: sets frame_err and restarts LOAD with the full LOAD_CYC count. No frame_done is produced.
- Horizontal decimation:
  - hacc is initialised to SRC_W−DST_W at every line start (first de_in=1 after de low).
  - For each pixel: s = hacc + DST_W. If s ≥ SRC_W, keep the pixel and set hacc = s − SRC_W; otherwise drop it and set hacc = s.
  - This keeps exactly DST_W of every SRC_W pixels; pixel 0 is always kept.
- Vertical decimation:
  - vacc is initialised to SRC_H−DST_H in LOAD.
  - The keep decision for a line is made from vacc at line start using the same rule. vacc is updated once per line.
  - A dropped line produces no wr_req.
- Accumulator width: clog2(SRC_W+DST_W) and clog2(SRC_H+DST_H) bits. Comparisons are unsigned with no truncation.
- Counters: src_x counts source pixels in the line; line_cnt counts lines; out_cnt counts wr_req pulses in the frame.
- Line checks:
  - A line longer than SRC_W: pixels beyond SRC_W are dropped and frame_err is set.
  - A line shorter than SRC_W: frame_err is set at de_fall.
- Frame check: at the last line's de_fall, frame_done pulses only if out_cnt = DST_W·DST_H. Otherwise frame_err is set and no pulse is produced.
- de_in high outside ACTIVE is ignored.

## Timing
- Reset values: wr_req=0, wr_data=0, wr_load=0, frame_done=0, frame_err=0, state=IDLE.
- vs_rise is detected one cycle after vs_in rises. wr_load rises on the next clk and stays high for LOAD_CYC cycles.
- Pixel latency: a pixel sampled on cycle n appears as wr_req/wr_data on cycle n+2 (edge register plus output register). The path is fully pipelined at one pixel per clock.
- frame_done is asserted on the cycle after the final kept pixel's wr_req, or on the cycle after the last line's de_fall if that comes later.
- wr_req is never asserted while wr_load=1.
- The FIFO is never back-pressured. Overflow protection is the downstream controller's burst scheduling.
- Asynchronous rst mid-frame clears all outputs immediately. Output resumes only after the next vs_rise.

## Test plan
- SRC 8×4 → DST 6×3, ramp pixel = 16·line + x: required output lines 0, 2, 3; columns 0, 2, 3, 4, 6, 7; 18 wr_req pulses; one frame_done; frame_err=0.
- Identity scaling SRC = DST = 8×4: all 32 pixels pass in order with 2-cycle latency; wr_load is high for exactly LOAD_CYC=8 cycles.
- vs_in pulse mid-frame (after line 1): frame_err=1; wr_load re-pulses for 8 cycles; no frame_done; the next full frame yields 18 pixels and frame_done.
- Short line (7 pixels) in the 8×4 → 6×3 case: frame_err=1 and no frame_done for that frame. A long line (10 pixels) drops pixels 8–9 and sets frame_err=1.
- rst asserted mid-line: all outputs are 0 within the same cycle. de_in without a vs_in edge produces no wr_req.
- Back-to-back frames with one idle cycle of vblank: two frame_done pulses, 36 total wr_req, and wr_req never overlaps wr_load.

Source files
------------

// File: rtl/lcd_frame_downscaler_if.sv
// Video-in / FIFO-write-port bundle for the frame downscaler.
// The slave modport is the downscaler; the master side feeds video and watches the write port.
interface lcd_frame_downscaler_if #(
  parameter int DATA_W = 16
);
  logic              vs_in;
  logic              de_in;
  logic [DATA_W-1:0] pix_in;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_load;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output vs_in, de_in, pix_in,
    input  wr_req, wr_data, wr_load, frame_done, frame_err
  );

  modport slave (
    input  vs_in, de_in, pix_in,
    output wr_req, wr_data, wr_load, frame_done, frame_err
  );
endinterface

// File: rtl/lcd_frame_downscaler.sv
// Nearest-neighbour frame downscaler feeding the SDRAM write-port FIFO.
// Decimates SRC_W x SRC_H to DST_W x DST_H with Bresenham accumulators,
// pulses wr_load at every frame start and flags short/long/aborted frames.
module lcd_frame_downscaler #(
  parameter int DATA_W   = 16,
  parameter int SRC_W    = 800,
  parameter int SRC_H    = 480,
  parameter int DST_W    = 480,
  parameter int DST_H    = 272,
  parameter int LOAD_CYC = 8
) (
  input logic clk,
  input logic rst,
  lcd_frame_downscaler_if.slave bus
);

  localparam int HACC_W = $clog2(SRC_W + DST_W);
  localparam int VACC_W = $clog2(SRC_H + DST_H);
  localparam int X_W    = $clog2(SRC_W + 1);
  localparam int LINE_W = $clog2(SRC_H + 1);
  localparam int OUT_W  = $clog2(DST_W * DST_H + 1);
  localparam int LCNT_W = $clog2(LOAD_CYC + 1);

  localparam logic [HACC_W-1:0] H_SRC  = HACC_W'(SRC_W);
  localparam logic [HACC_W-1:0] H_DST  = HACC_W'(DST_W);
  localparam logic [HACC_W-1:0] H_INIT = HACC_W'(SRC_W - DST_W);
  localparam logic [VACC_W-1:0] V_SRC  = VACC_W'(SRC_H);
  localparam logic [VACC_W-1:0] V_DST  = VACC_W'(DST_H);
  localparam logic [VACC_W-1:0] V_INIT = VACC_W'(SRC_H - DST_H);
  localparam logic [X_W-1:0]    X_MAX  = X_W'(SRC_W);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(SRC_H - 1);
  localparam logic [OUT_W-1:0]  OUT_FULL  = OUT_W'(DST_W * DST_H);
  localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(LOAD_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;

  state_t state, state_d;

  logic              vs_s, vs_r, de_s, de_r;
  logic [DATA_W-1:0] pix_s;
  logic [HACC_W-1:0] hacc;
  logic [VACC_W-1:0] vacc;
  logic [X_W-1:0]    src_x;
  logic [LINE_W-1:0] line_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [LCNT_W-1:0] load_cnt;
  logic              line_on, line_keep, frame_bad;
  logic              wr_req_q, wr_load_q, frame_done_q, frame_err_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              vs_rise, de_rise, de_fall, in_active;
  logic              line_start, pix_valid, line_end, last_line;
  logic [HACC_W-1:0] h_cur, h_sum;
  logic [VACC_W-1:0] v_sum;
  logic [X_W-1:0]    x_cur;
  logic              x_ok, line_keep_now, keep, short_line, long_px;
  logic              done_d, err_set;

  // Input register stage; also provides the delayed copies for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s  <= 1'b0;
      vs_r  <= 1'b0;
      de_s  <= 1'b0;
      de_r  <= 1'b0;
      pix_s <= '0;
    end else begin
      vs_s  <= bus.vs_in;
      vs_r  <= vs_s;
      de_s  <= bus.de_in;
      de_r  <= de_s;
      pix_s <= bus.pix_in;
    end
  end

  // Edge decode plus horizontal/vertical keep decisions for the registered pixel.
  always_comb begin
    vs_rise       = vs_s & ~vs_r;
    de_rise       = de_s & ~de_r;
    de_fall       = de_r & ~de_s;
    in_active     = (state == S_ACTIVE);
    line_start    = in_active & de_rise;
    pix_valid     = in_active & de_s & (de_rise | line_on);
    line_end      = in_active & de_fall & line_on;
    last_line     = line_end & (line_cnt == LINE_LAST);
    h_cur         = line_start ? H_INIT : hacc;
    h_sum         = h_cur + H_DST;
    x_cur         = line_start ? '0 : src_x;
    x_ok          = (x_cur < X_MAX);
    v_sum         = vacc + V_DST;
    line_keep_now = line_start ? (v_sum >= V_SRC) : line_keep;
    keep          = pix_valid & x_ok & line_keep_now & (h_sum >= H_SRC) & ~vs_rise;
    short_line    = line_end & (src_x != X_MAX);
    long_px       = pix_valid & ~x_ok;
    done_d        = last_line & ~vs_rise & ~frame_bad & ~short_line & (out_cnt == OUT_FULL);
    err_set       = (vs_rise & (state != S_IDLE)) | short_line | long_px |
                    (last_line & ~vs_rise & (out_cnt != OUT_FULL));
  end

  // Next-state logic: a new vs edge always wins and (re)starts the load window.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (vs_rise) state_d = S_LOAD;
      S_LOAD:   if (!vs_rise && load_cnt == LOAD_LAST) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (vs_rise)        state_d = S_LOAD;
        else if (last_line) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Accumulators and frame counters: cleared during LOAD, advanced per pixel/line in ACTIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hacc      <= '0;
      vacc      <= '0;
      src_x     <= '0;
      line_cnt  <= '0;
      out_cnt   <= '0;
      load_cnt  <= '0;
      line_on   <= 1'b0;
      line_keep <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      load_cnt <= (state == S_LOAD && !vs_rise) ? load_cnt + 1'b1 : '0;
      if (state == S_LOAD) begin
        hacc      <= H_INIT;
        vacc      <= V_INIT;
        src_x     <= '0;
        line_cnt  <= '0;
        out_cnt   <= '0;
        line_on   <= 1'b0;
        line_keep <= 1'b0;
        frame_bad <= 1'b0;
      end else begin
        if (err_set) frame_bad <= 1'b1;
        if (line_start) begin
          vacc      <= (v_sum >= V_SRC) ? v_sum - V_SRC : v_sum;
          line_keep <= (v_sum >= V_SRC);
          line_on   <= 1'b1;
        end
        if (pix_valid && x_ok) begin
          hacc  <= (h_sum >= H_SRC) ? h_sum - H_SRC : h_sum;
          src_x <= x_cur + 1'b1;
        end
        if (keep) out_cnt <= out_cnt + 1'b1;
        if (line_end) begin
          line_on  <= 1'b0;
          line_cnt <= line_cnt + 1'b1;
        end
      end
    end
  end

  // Output register stage; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_req_q     <= 1'b0;
      wr_data_q    <= '0;
      wr_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_req_q     <= keep;
      if (keep) wr_data_q <= pix_s;
      wr_load_q    <= (state_d == S_LOAD);
      frame_done_q <= done_d;
      if (err_set) frame_err_q <= 1'b1;
    end
  end

  assign bus.wr_req     = wr_req_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_load    = wr_load_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_lcd_frame_downscaler.sv
// Bench for lcd_frame_downscaler: one 8x4->6x3 instance and one 8x4 identity instance
// share the same random-pixel video stream and are checked against a closed-form model.
module tb_lcd_frame_downscaler;

  localparam int DATA_W   = 16;
  localparam int SRC_W    = 8;
  localparam int SRC_H    = 4;
  localparam int DST_W_A  = 6;
  localparam int DST_H_A  = 3;
  localparam int DST_W_B  = 8;
  localparam int DST_H_B  = 4;
  localparam int LOAD_CYC = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vs  = 1'b0;
  logic              de  = 1'b0;
  logic [DATA_W-1:0] pix = '0;

  lcd_frame_downscaler_if #(.DATA_W(DATA_W)) bus_a ();
  lcd_frame_downscaler_if #(.DATA_W(DATA_W)) bus_b ();

  assign bus_a.vs_in  = vs;
  assign bus_a.de_in  = de;
  assign bus_a.pix_in = pix;
  assign bus_b.vs_in  = vs;
  assign bus_b.de_in  = de;
  assign bus_b.pix_in = pix;

  lcd_frame_downscaler #(
    .DATA_W(DATA_W), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .DST_W(DST_W_A), .DST_H(DST_H_A), .LOAD_CYC(LOAD_CYC)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  lcd_frame_downscaler #(
    .DATA_W(DATA_W), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .DST_W(DST_W_B), .DST_H(DST_H_B), .LOAD_CYC(LOAD_CYC)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] obs_a[$], obs_b[$];
  logic [DATA_W-1:0] exp_a[$], exp_b[$];
  int base_a = 0, base_b = 0;
  int done_a = 0, done_b = 0;
  int load_a = 0, load_b = 0;
  int overlap_a = 0, overlap_b = 0;
  int exp_done_a = 0, exp_done_b = 0;
  bit exp_err = 1'b0;
  bit frame_open = 1'b0;

  // Output monitor for the downscaling instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_a.wr_req) obs_a.push_back(bus_a.wr_data);
    if (bus_a.frame_done) done_a++;
    if (bus_a.wr_load) load_a++;
    if (bus_a.wr_req && bus_a.wr_load) overlap_a++;
  end

  // Output monitor for the identity instance.
  always @(negedge clk) begin
    if (bus_b.wr_req) obs_b.push_back(bus_b.wr_data);
    if (bus_b.frame_done) done_b++;
    if (bus_b.wr_load) load_b++;
    if (bus_b.wr_req && bus_b.wr_load) overlap_b++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Index idx survives decimation iff the running kept-count floor((src-dst+(idx+1)*dst)/src) steps up there.
  function automatic bit keepIdx(input int idx, input int src, input int dst);
    return ((src + idx * dst) / src) != ((src - dst + idx * dst) / src);
  endfunction

  task automatic pulseVs();
    step(); vs = 1'b1;
    step();
    step(); vs = 1'b0;
  endtask

  task automatic applyStimulus(input int nlines, input int len0, input int len1, input int len2, input int len3);
    int lens[4];
    int la, lb;
    bit bad;
    lens = '{len0, len1, len2, len3};
    if (frame_open) exp_err = 1'b1;
    la = load_a;
    lb = load_b;
    pulseVs();
    repeat (10) step();
    checkOutput("load_width_a", 32'(load_a - la), 32'(LOAD_CYC));
    checkOutput("load_width_b", 32'(load_b - lb), 32'(LOAD_CYC));
    bad = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      if (lens[l] != SRC_W) bad = 1'b1;
      for (int x = 0; x < lens[l]; x++) begin
        step();
        de  = 1'b1;
        pix = {8'($urandom), 4'(l), 4'(x)};
        if (x < SRC_W && keepIdx(l, SRC_H, DST_H_A) && keepIdx(x, SRC_W, DST_W_A)) exp_a.push_back(pix);
        if (x < SRC_W && keepIdx(l, SRC_H, DST_H_B) && keepIdx(x, SRC_W, DST_W_B)) exp_b.push_back(pix);
      end
      step();
      de = 1'b0;
      if (l != nlines - 1) repeat ($urandom_range(0, 2)) step();
    end
    if (bad) exp_err = 1'b1;
    frame_open = (nlines < SRC_H);
    if (!frame_open && !bad) begin
      exp_done_a++;
      exp_done_b++;
    end
  endtask

  task automatic settle();
    de = 1'b0;
    repeat (6) step();
  endtask

  task automatic checkFrame(input string tag);
    checkOutput($sformatf("%s count_a", tag), 32'(obs_a.size() - base_a), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && base_a + i < obs_a.size(); i++)
      checkOutput($sformatf("%s pix_a[%0d]", tag, i), 32'(obs_a[base_a + i]), 32'(exp_a[i]));
    checkOutput($sformatf("%s count_b", tag), 32'(obs_b.size() - base_b), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && base_b + i < obs_b.size(); i++)
      checkOutput($sformatf("%s pix_b[%0d]", tag, i), 32'(obs_b[base_b + i]), 32'(exp_b[i]));
    base_a = obs_a.size();
    base_b = obs_b.size();
    exp_a.delete();
    exp_b.delete();
    checkOutput($sformatf("%s done_a", tag), 32'(done_a), 32'(exp_done_a));
    checkOutput($sformatf("%s done_b", tag), 32'(done_b), 32'(exp_done_b));
    checkOutput($sformatf("%s err_a", tag), 32'(bus_a.frame_err), 32'(exp_err));
    checkOutput($sformatf("%s err_b", tag), 32'(bus_b.frame_err), 32'(exp_err));
    checkOutput($sformatf("%s overlap_a", tag), 32'(overlap_a), 32'd0);
    checkOutput($sformatf("%s overlap_b", tag), 32'(overlap_b), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s wr_req_a", tag), 32'(bus_a.wr_req), 32'd0);
    checkOutput($sformatf("%s wr_data_a", tag), 32'(bus_a.wr_data), 32'd0);
    checkOutput($sformatf("%s wr_load_a", tag), 32'(bus_a.wr_load), 32'd0);
    checkOutput($sformatf("%s frame_done_a", tag), 32'(bus_a.frame_done), 32'd0);
    checkOutput($sformatf("%s frame_err_a", tag), 32'(bus_a.frame_err), 32'd0);
    checkOutput($sformatf("%s wr_req_b", tag), 32'(bus_b.wr_req), 32'd0);
    checkOutput($sformatf("%s wr_data_b", tag), 32'(bus_b.wr_data), 32'd0);
    checkOutput($sformatf("%s wr_load_b", tag), 32'(bus_b.wr_load), 32'd0);
    checkOutput($sformatf("%s frame_done_b", tag), 32'(bus_b.frame_done), 32'd0);
    checkOutput($sformatf("%s frame_err_b", tag), 32'(bus_b.frame_err), 32'd0);
  endtask

  task automatic doReset();
    de  = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    base_a = obs_a.size();
    base_b = obs_b.size();
    exp_a.delete();
    exp_b.delete();
    exp_err    = 1'b0;
    frame_open = 1'b0;
  endtask

  initial begin
    int n_a, n_b, d_a, d_b, l_a, l_b;

    $display("[TB] start");
    repeat (3) step();
    checkAllZero("reset");
    rst = 1'b0;
    step();

    $display("[TB] nominal frame");
    applyStimulus(4, 8, 8, 8, 8);
    settle();
    checkFrame("nominal");

    $display("[TB] back-to-back frames");
    n_a = obs_a.size();
    n_b = obs_b.size();
    applyStimulus(4, 8, 8, 8, 8);
    applyStimulus(4, 8, 8, 8, 8);
    settle();
    checkOutput("b2b total_a", 32'(obs_a.size() - n_a), 32'd36);
    checkOutput("b2b total_b", 32'(obs_b.size() - n_b), 32'd64);
    checkFrame("back_to_back");

    $display("[TB] short line");
    applyStimulus(4, 8, 7, 8, 8);
    settle();
    checkFrame("short_line");

    doReset();
    $display("[TB] long line");
    applyStimulus(4, 8, 8, 10, 8);
    settle();
    checkFrame("long_line");

    doReset();
    $display("[TB] vs pulse mid-frame");
    applyStimulus(2, 8, 8, 8, 8);
    applyStimulus(4, 8, 8, 8, 8);
    settle();
    checkFrame("mid_frame_vs");

    doReset();
    $display("[TB] reset mid-line");
    pulseVs();
    repeat (10) step();
    for (int x = 0; x < 5; x++) begin
      step();
      de  = 1'b1;
      pix = 16'($urandom);
    end
    checkOutput("pre_reset wr_req_a", 32'(bus_a.wr_req), 32'd1);
    checkOutput("pre_reset wr_req_b", 32'(bus_b.wr_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("mid_line_reset");
    step();
    rst = 1'b0;
    base_a = obs_a.size();
    base_b = obs_b.size();

    $display("[TB] de without vs");
    n_a = obs_a.size();
    n_b = obs_b.size();
    d_a = done_a;
    d_b = done_b;
    l_a = load_a;
    l_b = load_b;
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < SRC_W; x++) begin
        step();
        de  = 1'b1;
        pix = 16'($urandom);
      end
      step();
      de = 1'b0;
      step();
    end
    settle();
    checkOutput("no_vs wr_req_a", 32'(obs_a.size() - n_a), 32'd0);
    checkOutput("no_vs wr_req_b", 32'(obs_b.size() - n_b), 32'd0);
    checkOutput("no_vs wr_load_a", 32'(load_a - l_a), 32'd0);
    checkOutput("no_vs wr_load_b", 32'(load_b - l_b), 32'd0);
    checkOutput("no_vs done_a", 32'(done_a - d_a), 32'd0);
    checkOutput("no_vs done_b", 32'(done_b - d_b), 32'd0);
    checkOutput("no_vs err_a", 32'(bus_a.frame_err), 32'd0);
    checkOutput("no_vs err_b", 32'(bus_b.frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
